// File: rtl/baccarat_match_controller_if.sv
// -----------------------------------------------------------------------------
// baccarat_match_controller_if
//
// Signal bundle between the match controller and its surroundings. The top
// level supplies the start key, and the hand state machine supplies its status.
// The controller drives the hand pacing pulses, the tallies and the match
// result.
//
// Parameters:
//   CNT_W            width of the tally and round counters
//
// Signals:
//   start            level, begins a new match (top level -> controller)
//   hand_done        hand state machine is in its winner state
//   player_win_light player win light from the hand state machine
//   dealer_win_light dealer win light from the hand state machine
//   hand_reset       one-cycle clear pulse to the hand datapath/state machine
//   step_en          one-cycle advance pulse to the hand state machine
//   busy             a match is in progress
//   player_wins      player hand wins this match
//   dealer_wins      dealer hand wins this match
//   ties             tied hands this match
//   rounds           completed hands this match
//   match_over       match has finished
//   match_winner     00 draw, 01 player, 10 dealer, 11 error
//
// Modports:
//   master           controller side
//   slave            top level / hand state machine side
// -----------------------------------------------------------------------------
interface baccarat_match_controller_if #(
   parameter int unsigned CNT_W = 4
) ();

   logic             start;
   logic             hand_done;
   logic             player_win_light;
   logic             dealer_win_light;
   logic             hand_reset;
   logic             step_en;
   logic             busy;
   logic [CNT_W-1:0] player_wins;
   logic [CNT_W-1:0] dealer_wins;
   logic [CNT_W-1:0] ties;
   logic [CNT_W-1:0] rounds;
   logic             match_over;
   logic [1:0]       match_winner;

   modport master (
      input  start,
      input  hand_done,
      input  player_win_light,
      input  dealer_win_light,
      output hand_reset,
      output step_en,
      output busy,
      output player_wins,
      output dealer_wins,
      output ties,
      output rounds,
      output match_over,
      output match_winner
   );

   modport slave (
      output start,
      output hand_done,
      output player_win_light,
      output dealer_win_light,
      input  hand_reset,
      input  step_en,
      input  busy,
      input  player_wins,
      input  dealer_wins,
      input  ties,
      input  rounds,
      input  match_over,
      input  match_winner
   );

endinterface

// File: rtl/baccarat_match_controller.sv
// -----------------------------------------------------------------------------
// baccarat_match_controller
//
// Match-level sequencer for the baccarat hand datapath. For each hand, it
// issues a one-cycle hand_reset. It then paces single-cycle step_en pulses
// DEAL_GAP+1 cycles apart until the hand state machine reports hand_done. It
// then samples the win lights and updates the player/dealer/tie tallies. The
// match ends when either side reaches WIN_TARGET wins or when MAX_ROUNDS hands
// have been played. The match also ends with an error code in two cases: a hand
// never completes within MAX_STEPS steps, or a hand completes with neither
// light lit.
//
// Ports:
//   slow_clock  system clock, all logic on the rising edge
//   reset       synchronous, active-high reset
//   bus         controller side of baccarat_match_controller_if (see that file)
//
// All outputs are registered and decoded from the next state. As a result,
// every output is a pure function of the current state register.
// -----------------------------------------------------------------------------
module baccarat_match_controller #(
   parameter int unsigned CNT_W      = 4,
   parameter int unsigned DEAL_GAP   = 4,
   parameter int unsigned WIN_TARGET = 3,
   parameter int unsigned MAX_ROUNDS = 9,
   parameter int unsigned MAX_STEPS  = 8
) (
   input  logic                           slow_clock,
   input  logic                           reset,
   baccarat_match_controller_if.master    bus
);

   localparam int unsigned GapW  = $clog2(DEAL_GAP + 1);
   localparam int unsigned StepW = $clog2(MAX_STEPS + 1);

   localparam logic [1:0] WinDraw   = 2'b00;
   localparam logic [1:0] WinPlayer = 2'b01;
   localparam logic [1:0] WinDealer = 2'b10;
   localparam logic [1:0] WinError  = 2'b11;

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StStep,
      StGap,
      StResult,
      StCheck,
      StOver
   } state_e;

   state_e           state_q, state_d;
   logic [StepW-1:0] step_cnt_q, step_cnt_d;
   logic [GapW-1:0]  gap_cnt_q, gap_cnt_d;
   logic [CNT_W-1:0] player_q, player_d;
   logic [CNT_W-1:0] dealer_q, dealer_d;
   logic [CNT_W-1:0] ties_q, ties_d;
   logic [CNT_W-1:0] rounds_q, rounds_d;
   logic [1:0]       winner_q, winner_d;

   logic             hand_reset_q;
   logic             step_en_q;
   logic             busy_q;
   logic             over_q;

   // Next-state and datapath update
   always_comb begin
      state_d    = state_q;
      step_cnt_d = step_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      player_d   = player_q;
      dealer_d   = dealer_q;
      ties_d     = ties_q;
      rounds_d   = rounds_q;
      winner_d   = winner_q;

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               player_d = '0;
               dealer_d = '0;
               ties_d   = '0;
               rounds_d = '0;
               winner_d = WinDraw;
               state_d  = StClear;
            end
         end

         StClear: begin
            step_cnt_d = '0;
            state_d    = StStep;
         end

         StStep: begin
            step_cnt_d = step_cnt_q + StepW'(1);
            gap_cnt_d  = GapW'(DEAL_GAP - 1);
            state_d    = StGap;
         end

         // hand_done is only looked at once the gap has fully elapsed, so an
         // early assertion during the gap simply waits for the last cycle.
         StGap: begin
            if (gap_cnt_q != '0) begin
               gap_cnt_d = gap_cnt_q - GapW'(1);
            end else if (bus.hand_done) begin
               state_d = StResult;
            end else if (step_cnt_q == StepW'(MAX_STEPS)) begin
               // The hand never finished: abort the match with an error.
               winner_d = WinError;
               state_d  = StOver;
            end else begin
               state_d = StStep;
            end
         end

         StResult: begin
            unique case ({bus.player_win_light, bus.dealer_win_light})
               2'b11: begin
                  ties_d   = ties_q + CNT_W'(1);
                  rounds_d = rounds_q + CNT_W'(1);
                  state_d  = StCheck;
               end
               2'b10: begin
                  player_d = player_q + CNT_W'(1);
                  rounds_d = rounds_q + CNT_W'(1);
                  state_d  = StCheck;
               end
               2'b01: begin
                  dealer_d = dealer_q + CNT_W'(1);
                  rounds_d = rounds_q + CNT_W'(1);
                  state_d  = StCheck;
               end
               default: begin
                  // A completed hand with no winner light is inconsistent.
                  winner_d = WinError;
                  state_d  = StOver;
               end
            endcase
         end

         // The tallies were updated in RESULT, so the limits can be compared
         // directly. Because the match stops exactly at a limit, the counters
         // never need wrap handling.
         StCheck: begin
            if ((player_q == CNT_W'(WIN_TARGET)) ||
                (dealer_q == CNT_W'(WIN_TARGET)) ||
                (rounds_q == CNT_W'(MAX_ROUNDS))) begin
               if (player_q > dealer_q) begin
                  winner_d = WinPlayer;
               end else if (player_q < dealer_q) begin
                  winner_d = WinDealer;
               end else begin
                  winner_d = WinDraw;
               end
               state_d = StOver;
            end else begin
               state_d = StClear;
            end
         end

         StOver: begin
            if (bus.start) begin
               player_d = '0;
               dealer_d = '0;
               ties_d   = '0;
               rounds_d = '0;
               winner_d = WinDraw;
               state_d  = StClear;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State, counters and registered Moore outputs
   always_ff @(posedge slow_clock) begin
      if (reset) begin
         state_q      <= StIdle;
         step_cnt_q   <= '0;
         gap_cnt_q    <= '0;
         player_q     <= '0;
         dealer_q     <= '0;
         ties_q       <= '0;
         rounds_q     <= '0;
         winner_q     <= WinDraw;
         hand_reset_q <= 1'b0;
         step_en_q    <= 1'b0;
         busy_q       <= 1'b0;
         over_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         step_cnt_q   <= step_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
         player_q     <= player_d;
         dealer_q     <= dealer_d;
         ties_q       <= ties_d;
         rounds_q     <= rounds_d;
         winner_q     <= winner_d;
         hand_reset_q <= (state_d == StClear);
         step_en_q    <= (state_d == StStep);
         busy_q       <= (state_d != StIdle) && (state_d != StOver);
         over_q       <= (state_d == StOver);
      end
   end

   assign bus.hand_reset   = hand_reset_q;
   assign bus.step_en      = step_en_q;
   assign bus.busy         = busy_q;
   assign bus.player_wins  = player_q;
   assign bus.dealer_wins  = dealer_q;
   assign bus.ties         = ties_q;
   assign bus.rounds       = rounds_q;
   assign bus.match_over   = over_q;
   assign bus.match_winner = winner_q;

endmodule

// File: tb/tb_baccarat_match_controller.sv
module tb_baccarat_match_controller;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   baccarat_match_controller_if #(.CNT_W(4)) bus ();

   baccarat_match_controller #(
      .CNT_W      (4),
      .DEAL_GAP   (4),
      .WIN_TARGET (3),
      .MAX_ROUNDS (9),
      .MAX_STEPS  (8)
   ) dut (
      .slow_clock (clk),
      .reset      (rst),
      .bus        (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Outputs are sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hand model: waits for hand_reset, counts four step_en pulses, then
   // reports the hand complete with the given lights (held until next clear).
   task automatic play_hand(input logic pl, input logic dl, output bit ok);
      int n;
      int steps;
      ok = 1'b1;
      n  = 0;
      while (bus.hand_reset !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      if (bus.hand_reset !== 1'b1) ok = 1'b0;
      bus.hand_done        = 1'b0;
      bus.player_win_light = 1'b0;
      bus.dealer_win_light = 1'b0;
      steps = 0;
      n     = 0;
      while (ok && steps < 4 && n < 60) begin
         tick();
         n++;
         if (bus.step_en === 1'b1) steps++;
      end
      if (steps != 4) ok = 1'b0;
      bus.hand_done        = ok;
      bus.player_win_light = pl;
      bus.dealer_win_light = dl;
      tick();
   endtask

   task automatic wait_over(output bit ok);
      int n;
      n = 0;
      while (bus.match_over !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      ok = (bus.match_over === 1'b1);
   endtask

   // Starts a new match from OVER or IDLE; leaves the sample point in CLEAR.
   task automatic restart();
      bus.start = 1'b1;
      tick();
      bus.start     = 1'b0;
      bus.hand_done = 1'b0;
   endtask

   task automatic test_reset();
      rst                  = 1'b1;
      bus.start            = 1'b0;
      bus.hand_done        = 1'b0;
      bus.player_win_light = 1'b0;
      bus.dealer_win_light = 1'b0;
      repeat (3) tick();
      n_checks++;
      if ({bus.hand_reset, bus.step_en, bus.busy, bus.match_over} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_flags: got %b expected 0000",
                  {bus.hand_reset, bus.step_en, bus.busy, bus.match_over});
      end
      n_checks++;
      if ({bus.player_wins, bus.dealer_wins, bus.ties, bus.rounds, bus.match_winner} !== 18'd0)
      begin
         n_fail++;
         $display("FAIL reset_counters: got p=%0d d=%0d t=%0d r=%0d w=%b expected all zero",
                  bus.player_wins, bus.dealer_wins, bus.ties, bus.rounds, bus.match_winner);
      end
      rst = 1'b0;
      repeat (3) tick();
      n_checks++;
      if (bus.busy !== 1'b0 || bus.hand_reset !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_hold: got busy=%b hand_reset=%b expected 0 0",
                  bus.busy, bus.hand_reset);
      end
   endtask

   // Start latency, step pacing, and first hand (player win)
   task automatic test_start_latency();
      logic exp_step;
      logic exp_hr;
      int   bad_step;
      int   bad_hr;
      int   bad_busy;
      restart();
      n_checks++;
      if (bus.hand_reset !== 1'b1 || bus.step_en !== 1'b0 || bus.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL start_to_clear: got hr=%b se=%b busy=%b expected 1 0 1",
                  bus.hand_reset, bus.step_en, bus.busy);
      end
      bad_step = 0;
      bad_hr   = 0;
      bad_busy = 0;
      for (int i = 1; i <= 23; i++) begin
         tick();
         exp_step = (i == 1) || (i == 6) || (i == 11) || (i == 16);
         exp_hr   = (i == 23);
         if (bus.step_en !== exp_step) begin
            bad_step++;
            $display("FAIL step_en_tick%0d: got %b expected %b", i, bus.step_en, exp_step);
         end
         if (bus.hand_reset !== exp_hr) begin
            bad_hr++;
            $display("FAIL hand_reset_tick%0d: got %b expected %b", i, bus.hand_reset, exp_hr);
         end
         if (bus.busy !== 1'b1) bad_busy++;
         if (i == 16) begin
            bus.hand_done        = 1'b1;
            bus.player_win_light = 1'b1;
            bus.dealer_win_light = 1'b0;
         end
         if (i == 21) begin
            n_checks++;
            if (bus.player_wins !== 4'd0 || bus.rounds !== 4'd0) begin
               n_fail++;
               $display("FAIL result_cycle_tally: got p=%0d r=%0d expected 0 0",
                        bus.player_wins, bus.rounds);
            end
         end
         if (i == 22) begin
            n_checks++;
            if (bus.player_wins !== 4'd1 || bus.rounds !== 4'd1 ||
                bus.dealer_wins !== 4'd0 || bus.ties !== 4'd0) begin
               n_fail++;
               $display("FAIL first_hand_tally: got p=%0d d=%0d t=%0d r=%0d expected 1 0 0 1",
                        bus.player_wins, bus.dealer_wins, bus.ties, bus.rounds);
            end
         end
      end
      n_checks++;
      if (bad_step != 0) n_fail++;
      n_checks++;
      if (bad_hr != 0) n_fail++;
      n_checks++;
      if (bad_busy != 0) begin
         n_fail++;
         $display("FAIL busy_during_hand: got %0d low cycles expected 0", bad_busy);
      end
   endtask

   // Remaining hands D, T, P, P end the match with player at 3 wins
   task automatic test_player_match();
      bit ok;
      bit all_ok;
      all_ok = 1'b1;
      play_hand(1'b0, 1'b1, ok); all_ok &= ok;
      play_hand(1'b1, 1'b1, ok); all_ok &= ok;
      play_hand(1'b1, 1'b0, ok); all_ok &= ok;
      play_hand(1'b1, 1'b0, ok); all_ok &= ok;
      wait_over(ok);
      all_ok &= ok;
      n_checks++;
      if (!all_ok) begin
         n_fail++;
         $display("FAIL player_match_progress: got timeout expected match to complete");
      end
      n_checks++;
      if (bus.player_wins !== 4'd3 || bus.dealer_wins !== 4'd1 ||
          bus.ties !== 4'd1 || bus.rounds !== 4'd5) begin
         n_fail++;
         $display("FAIL player_match_tally: got p=%0d d=%0d t=%0d r=%0d expected 3 1 1 5",
                  bus.player_wins, bus.dealer_wins, bus.ties, bus.rounds);
      end
      n_checks++;
      if (bus.match_winner !== 2'b01 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL player_match_winner: got w=%b busy=%b expected 01 0",
                  bus.match_winner, bus.busy);
      end
      repeat (4) tick();
      n_checks++;
      if (bus.match_over !== 1'b1 || bus.player_wins !== 4'd3 || bus.step_en !== 1'b0) begin
         n_fail++;
         $display("FAIL over_hold: got over=%b p=%0d se=%b expected 1 3 0",
                  bus.match_over, bus.player_wins, bus.step_en);
      end
   endtask

   // Nine tied hands reach MAX_ROUNDS and end as a draw
   task automatic test_all_ties();
      bit ok;
      bit all_ok;
      restart();
      n_checks++;
      if (bus.hand_reset !== 1'b1 || bus.match_over !== 1'b0 || bus.player_wins !== 4'd0 ||
          bus.rounds !== 4'd0 || bus.match_winner !== 2'b00) begin
         n_fail++;
         $display("FAIL restart_clear: got hr=%b over=%b p=%0d r=%0d w=%b expected 1 0 0 0 00",
                  bus.hand_reset, bus.match_over, bus.player_wins, bus.rounds,
                  bus.match_winner);
      end
      all_ok = 1'b1;
      for (int h = 0; h < 9; h++) begin
         play_hand(1'b1, 1'b1, ok);
         all_ok &= ok;
      end
      wait_over(ok);
      all_ok &= ok;
      n_checks++;
      if (!all_ok || bus.ties !== 4'd9 || bus.rounds !== 4'd9 || bus.player_wins !== 4'd0 ||
          bus.match_winner !== 2'b00) begin
         n_fail++;
         $display("FAIL all_ties: got ok=%b t=%0d r=%0d p=%0d w=%b expected 1 9 9 0 00",
                  all_ok, bus.ties, bus.rounds, bus.player_wins, bus.match_winner);
      end
   endtask

   // Shared by the timeout and back-to-back tests: counts step_en pulses and
   // the tick at which match_over first appears (0 if never within bound).
   task automatic count_to_over(output int steps, output int over_tick);
      steps     = 0;
      over_tick = 0;
      for (int i = 1; i <= 60; i++) begin
         tick();
         if (bus.step_en === 1'b1) steps++;
         if (bus.match_over === 1'b1) begin
            over_tick = i;
            break;
         end
      end
   endtask

   // hand_done never arrives: exactly MAX_STEPS pulses, then an error result
   task automatic test_timeout();
      int steps;
      int over_tick;
      restart();
      count_to_over(steps, over_tick);
      n_checks++;
      if (steps != 8) begin
         n_fail++;
         $display("FAIL timeout_steps: got %0d expected 8", steps);
      end
      n_checks++;
      if (over_tick != 41) begin
         n_fail++;
         $display("FAIL timeout_over_tick: got %0d expected 41", over_tick);
      end
      n_checks++;
      if (bus.match_winner !== 2'b11 || bus.rounds !== 4'd0 || bus.ties !== 4'd0) begin
         n_fail++;
         $display("FAIL timeout_result: got w=%b r=%0d t=%0d expected 11 0 0",
                  bus.match_winner, bus.rounds, bus.ties);
      end
   endtask

   // Hand completes with neither light: error, no tally change
   task automatic test_no_light();
      bit ok;
      restart();
      play_hand(1'b0, 1'b0, ok);
      wait_over(ok);
      n_checks++;
      if (!ok || bus.match_winner !== 2'b11 || bus.rounds !== 4'd0 ||
          bus.player_wins !== 4'd0 || bus.dealer_wins !== 4'd0) begin
         n_fail++;
         $display("FAIL no_light_error: got ok=%b w=%b r=%0d p=%0d d=%0d expected 1 11 0 0 0",
                  ok, bus.match_winner, bus.rounds, bus.player_wins, bus.dealer_wins);
      end
   endtask

   // Reset during the gap of hand 2 aborts immediately
   task automatic test_reset_mid_hand();
      bit ok;
      int n;
      int pulses;
      restart();
      play_hand(1'b1, 1'b0, ok);
      n = 0;
      while (bus.hand_reset !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      bus.hand_done = 1'b0;
      n = 0;
      while (bus.step_en !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      n_checks++;
      if (!ok || bus.player_wins !== 4'd1) begin
         n_fail++;
         $display("FAIL pre_abort_tally: got ok=%b p=%0d expected 1 1", ok, bus.player_wins);
      end
      repeat (2) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if (bus.busy !== 1'b0 || bus.step_en !== 1'b0 || bus.hand_reset !== 1'b0 ||
          bus.match_over !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_flags: got busy=%b se=%b hr=%b over=%b expected 0 0 0 0",
                  bus.busy, bus.step_en, bus.hand_reset, bus.match_over);
      end
      n_checks++;
      if (bus.player_wins !== 4'd0 || bus.rounds !== 4'd0 || bus.match_winner !== 2'b00) begin
         n_fail++;
         $display("FAIL abort_counters: got p=%0d r=%0d w=%b expected 0 0 00",
                  bus.player_wins, bus.rounds, bus.match_winner);
      end
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.step_en === 1'b1 || bus.hand_reset === 1'b1) pulses++;
      end
      n_checks++;
      if (pulses != 0) begin
         n_fail++;
         $display("FAIL abort_stays_idle: got %0d pulses expected 0", pulses);
      end
   endtask

   // start held high: matches run back to back, OVER lasts one cycle
   task automatic test_back_to_back();
      int steps;
      int over_tick;
      bus.hand_done = 1'b0;
      bus.start     = 1'b1;
      tick();
      count_to_over(steps, over_tick);
      n_checks++;
      if (over_tick != 41 || steps != 8 || bus.match_winner !== 2'b11) begin
         n_fail++;
         $display("FAIL b2b_first_match: got tick=%0d steps=%0d w=%b expected 41 8 11",
                  over_tick, steps, bus.match_winner);
      end
      tick();
      n_checks++;
      if (bus.match_over !== 1'b0 || bus.hand_reset !== 1'b1 || bus.match_winner !== 2'b00) begin
         n_fail++;
         $display("FAIL b2b_restart: got over=%b hr=%b w=%b expected 0 1 00",
                  bus.match_over, bus.hand_reset, bus.match_winner);
      end
      bus.start = 1'b0;
      rst       = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_start_latency();
      test_player_match();
      test_all_ties();
      test_timeout();
      test_no_light();
      test_reset_mid_hand();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
